// File: rtl/lap_ctrl_if.sv
// ============================================================================
//  Module : lap_ctrl_if
//  Brief  : Button, counter and display signals of the stopwatch lap controller.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface lap_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int W     = 24
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          start;
    logic          lap;
    logic          recall;
    logic          ovf;
    logic [W-1:0]  cur_time;
    logic          run;
    logic          clr;
    logic [W-1:0]  disp;
    logic [CW-1:0] lapcnt;
    logic          full;
    logic [1:0]    mode;

    modport master (
        output start, lap, recall, ovf, cur_time,
        input  run, clr, disp, lapcnt, full, mode
    );

    modport slave (
        input  start, lap, recall, ovf, cur_time,
        output run, clr, disp, lapcnt, full, mode
    );
endinterface

`default_nettype wire

// File: rtl/lap_ctrl.sv
// ============================================================================
//  Module : lap_ctrl
//  Brief  : Run/stop/lap sequencer with lap register file and display select.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module lap_ctrl #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lap_ctrl_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_SPLIT = 2'b10,
        S_STOP  = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_disp;
    logic [W-1:0]  w_disp_nxt;
    logic [CW-1:0] r_lapcnt;
    logic [CW-1:0] w_lapcnt_nxt;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] w_idx_nxt;
    logic          r_clr;
    logic          w_clr_nxt;
    logic          r_run;
    logic          r_full;
    logic          w_wr;
    logic          w_running;
    logic          w_is_full;

    // Sized to the counter range so any index value is in bounds; only DEPTH slots are written.
    logic [W-1:0]  r_mem [0:(2**CW)-1];

    assign w_running = (r_state == S_RUN) || (r_state == S_SPLIT);
    assign w_is_full = (r_lapcnt == CW'(DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        w_disp_nxt   = r_disp;
        w_lapcnt_nxt = r_lapcnt;
        w_idx_nxt    = r_idx;
        w_clr_nxt    = 1'b0;
        w_wr         = 1'b0;

        if (bus.ovf && w_running) begin
            w_state_nxt = S_STOP;
            w_disp_nxt  = bus.cur_time;
        end else if (bus.start) begin
            w_disp_nxt = bus.cur_time;
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_STOP: begin
                    w_state_nxt = S_RUN;
                    w_idx_nxt   = '0;
                end
                default: w_state_nxt = S_STOP;
            endcase
        end else if (bus.lap) begin
            case (r_state)
                S_IDLE:  w_disp_nxt = bus.cur_time;
                S_STOP: begin
                    w_state_nxt  = S_IDLE;
                    w_clr_nxt    = 1'b1;
                    w_lapcnt_nxt = '0;
                    w_idx_nxt    = '0;
                    w_disp_nxt   = '0;
                end
                default: begin
                    w_state_nxt = S_SPLIT;
                    w_disp_nxt  = bus.cur_time;
                    if (!w_is_full) begin
                        w_wr         = 1'b1;
                        w_lapcnt_nxt = r_lapcnt + CW'(1);
                    end
                end
            endcase
        end else if (bus.recall) begin
            case (r_state)
                S_STOP: begin
                    // Circular walk: live, lap0 .. lapN-1, live, ...
                    if (r_lapcnt != '0) begin
                        if (r_idx < r_lapcnt) begin
                            w_disp_nxt = r_mem[r_idx];
                            w_idx_nxt  = r_idx + CW'(1);
                        end else begin
                            w_disp_nxt = bus.cur_time;
                            w_idx_nxt  = '0;
                        end
                    end
                end
                S_SPLIT: begin
                    w_state_nxt = S_RUN;
                    w_disp_nxt  = bus.cur_time;
                end
                default: w_disp_nxt = bus.cur_time;
            endcase
        end else if ((r_state == S_IDLE) || (r_state == S_RUN)) begin
            w_disp_nxt = bus.cur_time;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_disp   <= '0;
            r_lapcnt <= '0;
            r_idx    <= '0;
            r_clr    <= 1'b0;
            r_run    <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_disp   <= w_disp_nxt;
            r_lapcnt <= w_lapcnt_nxt;
            r_idx    <= w_idx_nxt;
            r_clr    <= w_clr_nxt;
            r_run    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_SPLIT);
            r_full   <= (w_lapcnt_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_wr) begin
            r_mem[r_lapcnt] <= bus.cur_time;
        end
    end

    assign bus.run    = r_run;
    assign bus.clr    = r_clr;
    assign bus.disp   = r_disp;
    assign bus.lapcnt = r_lapcnt;
    assign bus.full   = r_full;
    assign bus.mode   = r_state;
endmodule

`default_nettype wire
